// File: rtl/rgb2ycbcr_stream.sv
// RGB to YCbCr colour converter: full-range JPEG, BT.601 studio or passthrough, selected per pixel.
// Latency: 3 cycles from input transfer to VALID_O; sustains one pixel per cycle.
// Backpressure: each stage loads when the stage after it is empty or draining; empty stages fill under a stall.
module rgb2ycbcr_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_FRAC  = 15
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic [3*DATA_WIDTH-1:0] RGB_I,
  input  logic                    VALID_I,
  output logic                    READY_O,
  input  logic [1:0]              MODE_I,
  input  logic                    LAST_I,
  output logic [DATA_WIDTH-1:0]   Y_O,
  output logic [DATA_WIDTH-1:0]   CB_O,
  output logic [DATA_WIDTH-1:0]   CR_O,
  output logic                    VALID_O,
  input  logic                    READY_I,
  output logic                    LAST_O
);

  localparam int N  = DATA_WIDTH;
  // Product of an unsigned N-bit component and a signed coefficient.
  // Magnitude never exceeds (2^N-1)*2^15, so N+17 signed bits hold it exactly.
  localparam int PW = N + 17;
  // Sum of three products, the offset and the rounding constant.
  localparam int SW = N + 19;

  // Q1.15 coefficient tables, row-major: Y row, Cb row, Cr row; columns R, G, B.
  // 17 bits wide so that the passthrough weight of 1.0 (32768) is representable.
  localparam logic signed [16:0] COEF_M0 [9] = '{
    17'sd9798,   17'sd19235,  17'sd3735,
    -17'sd5529,  -17'sd10855, 17'sd16384,
    17'sd16384,  -17'sd13720, -17'sd2664
  };
  localparam logic signed [16:0] COEF_M1 [9] = '{
    17'sd8414,   17'sd16519,  17'sd3208,
    -17'sd4857,  -17'sd9535,  17'sd14392,
    17'sd14392,  -17'sd12052, -17'sd2340
  };
  localparam logic signed [16:0] COEF_M2 [9] = '{
    17'sd32768,  17'sd0,      17'sd0,
    17'sd0,      17'sd32768,  17'sd0,
    17'sd0,      17'sd0,      17'sd32768
  };

  // Chroma offset is mid-scale in both converting modes; studio luma sits at 16 scaled to N bits.
  localparam logic [N-1:0]        OFF_C  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]        OFF_Y1 = N'(16 << (N - 8));
  localparam logic signed [SW-1:0] RND   = SW'(1 << (COEF_FRAC - 1));

  // Clamp a shifted sum to the unsigned N-bit output range.
  function automatic logic [N-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1]) begin
      sat = '0;
    end else if (|v[SW-2:N]) begin
      sat = '1;
    end else begin
      sat = v[N-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake: a stage may load when its successor is empty or advancing.
  // ---------------------------------------------------------------------------
  logic w_s1_en;
  logic w_s2_en;
  logic w_s3_en;

  logic r_s1_vld;
  logic r_s2_vld;
  logic r_s3_vld;

  assign w_s3_en = !r_s3_vld || READY_I;
  assign w_s2_en = !r_s2_vld || w_s3_en;
  assign w_s1_en = !r_s1_vld || w_s2_en;
  assign READY_O = w_s1_en;

  // ---------------------------------------------------------------------------
  // Stage 1 inputs: component split and coefficient selection.
  // ---------------------------------------------------------------------------
  logic [N-1:0]          w_comp [3];
  logic signed [16:0]    w_coef [9];
  logic signed [PW-1:0]  w_prod [9];

  assign w_comp[0] = RGB_I[3*N-1:2*N];
  assign w_comp[1] = RGB_I[2*N-1:N];
  assign w_comp[2] = RGB_I[N-1:0];

  // Pick the coefficient set for the incoming pixel; reserved mode 3 converts as JPEG.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_coef[i] = COEF_M0[i];
      case (MODE_I)
        2'd1:    w_coef[i] = COEF_M1[i];
        2'd2:    w_coef[i] = COEF_M2[i];
        default: w_coef[i] = COEF_M0[i];
      endcase
    end
  end

  // Nine component x coefficient products; the result fits PW bits so modular PW-bit math is exact.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_prod[i] = $signed({{(PW-N){1'b0}}, w_comp[i % 3]})
                * $signed({{(PW-17){w_coef[i][16]}}, w_coef[i]});
    end
  end

  logic signed [PW-1:0] r_prod [9];
  logic [1:0]           r_s1_mode;
  logic                 r_s1_last;

  // Stage 1 register: products plus the pixel's mode and frame-end flag.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_s1_vld  <= 1'b0;
      r_s1_mode <= 2'd0;
      r_s1_last <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_prod[i] <= '0;
      end
    end else if (w_s1_en) begin
      r_s1_vld <= VALID_I;
      if (VALID_I) begin
        r_s1_mode <= MODE_I;
        r_s1_last <= LAST_I;
        for (int i = 0; i < 9; i++) begin
          r_prod[i] <= w_prod[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-channel sum with offset and round-half-up constant.
  // ---------------------------------------------------------------------------
  logic [N-1:0]         w_off [3];
  logic signed [SW-1:0] w_sum [3];

  // Offsets follow the mode that travelled with this pixel; passthrough adds none.
  always_comb begin
    w_off[0] = '0;
    w_off[1] = OFF_C;
    w_off[2] = OFF_C;
    case (r_s1_mode)
      2'd1: w_off[0] = OFF_Y1;
      2'd2: begin
        w_off[1] = '0;
        w_off[2] = '0;
      end
      default: ;
    endcase
  end

  // Offset is pre-scaled into the Q.15 domain so one shift later removes both.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      w_sum[ch] = $signed({{(SW-PW){r_prod[3*ch][PW-1]}},   r_prod[3*ch]})
                + $signed({{(SW-PW){r_prod[3*ch+1][PW-1]}}, r_prod[3*ch+1]})
                + $signed({{(SW-PW){r_prod[3*ch+2][PW-1]}}, r_prod[3*ch+2]})
                + $signed({{(SW-N-COEF_FRAC){1'b0}}, w_off[ch], {COEF_FRAC{1'b0}}})
                + RND;
    end
  end

  logic signed [SW-1:0] r_sum [3];
  logic                 r_s2_last;

  // Stage 2 register: rounded channel sums.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        r_sum[ch] <= '0;
      end
    end else if (w_s2_en) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_last <= r_s1_last;
        for (int ch = 0; ch < 3; ch++) begin
          r_sum[ch] <= w_sum[ch];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: drop the fraction and clamp into the output registers.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] w_shift [3];

  // Arithmetic shift keeps the sign so negative chroma/luma clamps to zero.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      w_shift[ch] = r_sum[ch] >>> COEF_FRAC;
    end
  end

  logic [N-1:0] r_y;
  logic [N-1:0] r_cb;
  logic [N-1:0] r_cr;
  logic         r_s3_last;

  // Stage 3 register: holds its pixel unchanged while downstream stalls.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_s3_vld  <= 1'b0;
      r_s3_last <= 1'b0;
      r_y       <= '0;
      r_cb      <= '0;
      r_cr      <= '0;
    end else if (w_s3_en) begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_last <= r_s2_last;
        r_y       <= sat(w_shift[0]);
        r_cb      <= sat(w_shift[1]);
        r_cr      <= sat(w_shift[2]);
      end
    end
  end

  assign VALID_O = r_s3_vld;
  assign LAST_O  = r_s3_last;
  assign Y_O     = r_y;
  assign CB_O    = r_cb;
  assign CR_O    = r_cr;

endmodule
